ahb_rom_slave: RTL and testbench
================================

Name: ahb_rom_slave

Overview:
- Parametrised AHB-Lite slave wrapper for the synchronous boot/data ROM.
- Successor to the fixed single-master, fixed-latency ROM slave.
- Adds:
  - configurable data and address width;
  - configurable ROM read latency;
  - bitmask of permitted masters;
  - pipelined back-to-back reads;
  - proper two-cycle AHB ERROR response for writes, illegal masters and oversize transfers.
- Sits between the AHB bus decoder/mux and the ROM macro.

Parameters:
- ADDR_W, 32, AHB address width.
- DATA_W, 32, AHB/ROM data width (32 or 64).
- ROM_AW, 14, ROM word-address width.
- WAIT_CYC, 1, ROM read latency in cycles (0..7); 0 means combinational ROM.
- MST_MASK, 16'h0004, bit i set means HMASTER==i may access the ROM.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- HSEL  in  1  slave select from decoder
- HADDR  in  ADDR_W  address
- HTRANS  in  2  IDLE/BUSY/NONSEQ/SEQ
- HWRITE  in  1  write flag
- HSIZE  in  3  transfer size
- HMASTER  in  4  current master id
- HREADY  in  1  bus-level ready (previous data phase done)
- HRDATA_S  out  DATA_W  read data
- HREADYOUT_S  out  1  slave ready
- HRESP_S  out  2  OKAY=2'b00, ERROR=2'b01
- ROM_DO  in  DATA_W  ROM read data
- ROM_EN  out  1  ROM chip enable
- ROM_OE  out  1  ROM output enable
- ROM_A  out  ROM_AW  ROM word address

Behaviour:
- Reset values (rst low, immediate): HRDATA_S=0, HREADYOUT_S=1, HRESP_S=OKAY, ROM_EN=0, ROM_OE=0, ROM_A=0, state IDLE.
- Valid transfer: sampled on a rising edge when HSEL & HREADY & HTRANS[1]. Any other edge accepts nothing.
- IDLE or BUSY with HSEL: zero-wait OKAY.
- Illegal transfer: HWRITE=1, or MST_MASK[HMASTER]=0, or HSIZE > log2(DATA_W/8).
- Legal read: latch ROM_A = HADDR[ROM_AW+B-1:B], with B = log2(DATA_W/8). Sub-word reads return the full word. Low address bits are ignored.
- States:
  - IDLE: HREADYOUT_S=1, OKAY, ROM_EN=0, ROM_OE=0. Legal read -> WAIT (WAIT_CYC>0) or DATA (WAIT_CYC==0). Illegal -> ERR1.
  - WAIT: ROM_EN=1, ROM_OE=1, HREADYOUT_S=0. Down-counter wcnt loaded with WAIT_CYC-1. At 0 -> DATA.
  - DATA: ROM_EN=1, ROM_OE=1, HREADYOUT_S=1, HRDATA_S=ROM_DO, OKAY.
    - Legal read sampled this edge: reload ROM_A, then -> WAIT or DATA.
    - Illegal sampled: -> ERR1.
    - Otherwise: -> IDLE.
  - ERR1: HREADYOUT_S=0, HRESP_S=ERROR -> ERR2.
  - ERR2: HREADYOUT_S=1, HRESP_S=ERROR, ROM_EN=0.
    - Legal or illegal transfer sampled this edge is handled exactly as from IDLE.
    - Otherwise -> IDLE.
- Latency: read accepted at edge T completes (HREADYOUT_S=1) in cycle T+1+WAIT_CYC. Back-to-back reads cost WAIT_CYC+1 cycles each.
- HRDATA_S=0 whenever the state is not DATA.
- ROM_A holds its last value outside accesses.
- wcnt width: $clog2(WAIT_CYC+1), minimum 1.
- Reset mid-access: the transfer is dropped and no response is completed. The bus master is also in reset.
- HSEL deasserted during WAIT: the access still completes (the data phase is owed).

Optional Feature:
- Macro: AHB_ROM_RDCNT_EN.
- When defined: extra output port rd_cnt, 32 bits.
  - Increments by 1 on each DATA-state cycle, i.e. each completed OKAY read.
  - Saturates at 32'hFFFF_FFFF.
  - Reset value 0.
- When undefined: the port and counter are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package ahb_rom_pkg holds:
  - state enum (IDLE, WAIT, DATA, ERR1, ERR2);
  - HTRANS encodings;
  - HRESP encodings OKAY/ERROR;
  - size-limit helper function.
- One sub-module: ahb_rom_wait_cnt, the parametrised down-counter with load/done.

Test Plan:
- Reset then idle: rst low at t=0 -> HREADYOUT_S=1, HRESP_S=00, ROM_EN=0, HRDATA_S=0.
- Single read, WAIT_CYC=1, HMASTER=2, HADDR=0x0000_0010, NONSEQ, HSIZE=2; ROM_DO=0xDEAD_BEEF:
  - ROM_A=4 on T+1;
  - HREADYOUT_S=0 at T+1;
  - HREADYOUT_S=1, HRDATA_S=0xDEADBEEF, OKAY at T+2.
- Back-to-back: NONSEQ 0x0 then SEQ 0x4 -> ROM_A 0 then 1; two OKAY completions 2 cycles apart; no idle bubble.
- Write, HWRITE=1 -> cycle1 HREADYOUT_S=0 ERROR; cycle2 HREADYOUT_S=1 ERROR; ROM_EN stays 0.
- Illegal master HMASTER=1 with MST_MASK=16'h0004 -> two-cycle ERROR. Next legal read from HMASTER=2 accepted in ERR2 and completes OKAY.
- Reset during WAIT with WAIT_CYC=3 -> outputs return immediately to reset values. With AHB_ROM_RDCNT_EN, rd_cnt=0 after reset and equals 5 after 5 completed reads.

Source files
------------

// File: rtl/ahb_rom_pkg.sv
// ahb_rom_pkg: shared state encoding, AHB encodings and the transfer-size
// helper used by the AHB-Lite ROM slave.
package ahb_rom_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    // A transfer fits when its byte size does not exceed the bus width.
    function automatic logic size_ok(input logic [2:0] hsize, input int unsigned max_log2);
        return ({29'd0, hsize} <= max_log2);
    endfunction

endpackage

// File: rtl/ahb_rom_wait_cnt.sv
// ahb_rom_wait_cnt: down-counter that times the ROM read latency; load starts
// a wait, done flags the last wait cycle.
import ahb_rom_pkg::*;

module ahb_rom_wait_cnt #(
    parameter int W        = 1,
    parameter int LOAD_VAL = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic dec_i,
    output logic done_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // NOTE: combinational blocks assign every output a default first so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = W'(LOAD_VAL);
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/ahb_rom_slave.sv
// ahb_rom_slave: AHB-Lite slave wrapper for the synchronous boot/data ROM.
// Define AHB_ROM_RDCNT_EN to add the saturating rd_cnt completed-read counter.
import ahb_rom_pkg::*;

module ahb_rom_slave #(
    parameter int          ADDR_W   = 32,
    parameter int          DATA_W   = 32,
    parameter int          ROM_AW   = 14,
    parameter int          WAIT_CYC = 1,
    parameter logic [15:0] MST_MASK = 16'h0004
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              HSEL,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [3:0]        HMASTER,
    input  logic              HREADY,
    output logic [DATA_W-1:0] HRDATA_S,
    output logic              HREADYOUT_S,
    output logic [1:0]        HRESP_S,
    input  logic [DATA_W-1:0] ROM_DO,
    output logic              ROM_EN,
    output logic              ROM_OE,
    output logic [ROM_AW-1:0] ROM_A
`ifdef AHB_ROM_RDCNT_EN
    ,
    output logic [31:0]       rd_cnt
`endif
);

    localparam int unsigned B         = $clog2(DATA_W / 8);
    localparam int          WCNT_W    = (WAIT_CYC > 0) ? $clog2(WAIT_CYC + 1) : 1;
    localparam int          WCNT_LOAD = (WAIT_CYC > 0) ? WAIT_CYC - 1 : 0;
    localparam state_e      RD_NEXT   = (WAIT_CYC > 0) ? ST_WAIT : ST_DATA;

    state_e            state_q, state_d;
    logic [ROM_AW-1:0] rom_a_q, rom_a_d;
    logic              xfer_valid, xfer_illegal, can_accept;
    logic              wcnt_load, wcnt_done;
    logic              unused_addr_bits;

    assign xfer_valid   = HSEL & HREADY & ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ));
    assign xfer_illegal = HWRITE | ~MST_MASK[HMASTER] | ~size_ok(HSIZE, B);
    assign unused_addr_bits = ^HADDR;

    always_comb begin
        state_d     = state_q;
        rom_a_d     = rom_a_q;
        wcnt_load   = 1'b0;
        can_accept  = 1'b0;
        HREADYOUT_S = 1'b1;
        HRESP_S     = HRESP_OKAY;
        HRDATA_S    = '0;
        ROM_EN      = 1'b0;
        ROM_OE      = 1'b0;

        unique case (state_q)
            ST_IDLE: can_accept = 1'b1;
            ST_WAIT: begin
                ROM_EN      = 1'b1;
                ROM_OE      = 1'b1;
                HREADYOUT_S = 1'b0;
                if (wcnt_done) state_d = ST_DATA;
            end
            ST_DATA: begin
                ROM_EN     = 1'b1;
                ROM_OE     = 1'b1;
                HRDATA_S   = ROM_DO;
                can_accept = 1'b1;
            end
            ST_ERR1: begin
                HREADYOUT_S = 1'b0;
                HRESP_S     = HRESP_ERROR;
                state_d     = ST_ERR2;
            end
            ST_ERR2: begin
                HRESP_S    = HRESP_ERROR;
                can_accept = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        // IDLE, DATA and ERR2 end an address phase, so they share the accept decision.
        if (can_accept) begin
            state_d = ST_IDLE;
            if (xfer_valid) begin
                if (xfer_illegal) begin
                    state_d = ST_ERR1;
                end else begin
                    rom_a_d   = HADDR[ROM_AW+B-1:B];
                    wcnt_load = 1'b1;
                    state_d   = RD_NEXT;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            rom_a_q <= '0;
        end else begin
            state_q <= state_d;
            rom_a_q <= rom_a_d;
        end
    end

    assign ROM_A = rom_a_q;

    ahb_rom_wait_cnt #(
        .W        (WCNT_W),
        .LOAD_VAL (WCNT_LOAD)
    ) u_wait_cnt (
        .clk    (clk),
        .rst    (rst),
        .load_i (wcnt_load),
        .dec_i  (state_q == ST_WAIT),
        .done_o (wcnt_done)
    );

`ifdef AHB_ROM_RDCNT_EN
    logic [31:0] rd_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_cnt_q <= '0;
        end else if ((state_q == ST_DATA) && (rd_cnt_q != 32'hFFFF_FFFF)) begin
            rd_cnt_q <= rd_cnt_q + 32'd1;
        end
    end

    assign rd_cnt = rd_cnt_q;
`endif

endmodule

// File: tb/tb_ahb_rom_slave.sv
// tb_ahb_rom_slave: directed and randomized AHB traffic checked cycle by cycle
// against a transaction-level response queue; honours AHB_ROM_RDCNT_EN.
module tb_ahb_rom_slave;

    localparam int          ADDR_W   = 32;
    localparam int          DATA_W   = 32;
    localparam int          ROM_AW   = 14;
    localparam int          WAIT_CYC = 1;
    localparam logic [15:0] MST_MASK = 16'h0004;
    localparam int          B        = 2;

    typedef struct packed {
        logic              sel;
        logic [1:0]        trans;
        logic              wr;
        logic [2:0]        size;
        logic [3:0]        mst;
        logic [ADDR_W-1:0] addr;
    } xfer_t;

    // Expected bus-visible outputs for one clock cycle.
    typedef struct packed {
        logic              ready;
        logic              err;
        logic              en;
        logic [DATA_W-1:0] data;
    } exp_t;

    localparam exp_t IDLE_EXP = '{ready: 1'b1, err: 1'b0, en: 1'b0, data: '0};

    logic              clk = 1'b0;
    logic              rst;
    logic              HSEL;
    logic [ADDR_W-1:0] HADDR;
    logic [1:0]        HTRANS;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic [3:0]        HMASTER;
    logic              HREADY;
    logic [DATA_W-1:0] HRDATA_S;
    logic              HREADYOUT_S;
    logic [1:0]        HRESP_S;
    logic [DATA_W-1:0] ROM_DO;
    logic              ROM_EN;
    logic              ROM_OE;
    logic [ROM_AW-1:0] ROM_A;
    logic              bus_stall;
`ifdef AHB_ROM_RDCNT_EN
    logic [31:0]       rd_cnt;
`endif

    exp_t              exp_q[$];
    logic [ROM_AW-1:0] exp_a;
    int unsigned       exp_rd;
    int                n_checks;
    int                n_fail;

    always #5 clk = ~clk;

    // Another slave may hold the bus while this one is idle.
    assign HREADY = HREADYOUT_S & ~bus_stall;

    function automatic logic [DATA_W-1:0] rom_fn(input logic [ROM_AW-1:0] a);
        logic [31:0] x;
        if (a == 14'd4) return 32'hDEAD_BEEF;
        x = {16'h0000, a, 2'b01};
        x = (x * 32'h9E37_79B1) ^ 32'h5A5A_0000;
        return x;
    endfunction

    assign ROM_DO = rom_fn(ROM_A);

    ahb_rom_slave #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .ROM_AW   (ROM_AW),
        .WAIT_CYC (WAIT_CYC),
        .MST_MASK (MST_MASK)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .HSEL        (HSEL),
        .HADDR       (HADDR),
        .HTRANS      (HTRANS),
        .HWRITE      (HWRITE),
        .HSIZE       (HSIZE),
        .HMASTER     (HMASTER),
        .HREADY      (HREADY),
        .HRDATA_S    (HRDATA_S),
        .HREADYOUT_S (HREADYOUT_S),
        .HRESP_S     (HRESP_S),
        .ROM_DO      (ROM_DO),
        .ROM_EN      (ROM_EN),
        .ROM_OE      (ROM_OE),
        .ROM_A       (ROM_A)
`ifdef AHB_ROM_RDCNT_EN
        ,
        .rd_cnt      (rd_cnt)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic check_outputs();
        exp_t e;
        e = (exp_q.size() > 0) ? exp_q[0] : IDLE_EXP;
        check("hreadyout", 64'(HREADYOUT_S), 64'(e.ready));
        check("hresp", 64'(HRESP_S), e.err ? 64'd1 : 64'd0);
        check("hrdata", 64'(HRDATA_S), 64'(e.data));
        check("rom_en", 64'(ROM_EN), 64'(e.en));
        check("rom_oe", 64'(ROM_OE), 64'(e.en));
        check("rom_a", 64'(ROM_A), 64'(exp_a));
`ifdef AHB_ROM_RDCNT_EN
        check("rd_cnt", 64'(rd_cnt), 64'(exp_rd));
`endif
    endtask

    // Queue the whole response of an accepted transfer, one entry per cycle.
    task automatic push_response(input xfer_t x);
        logic legal;
        legal = !x.wr && MST_MASK[x.mst] && (x.size <= 3'(B));
        if (legal) begin
            exp_a = x.addr[ROM_AW+B-1:B];
            for (int i = 0; i < WAIT_CYC; i++)
                exp_q.push_back('{ready: 1'b0, err: 1'b0, en: 1'b1, data: '0});
            exp_q.push_back('{ready: 1'b1, err: 1'b0, en: 1'b1, data: rom_fn(exp_a)});
        end else begin
            exp_q.push_back('{ready: 1'b0, err: 1'b1, en: 1'b0, data: '0});
            exp_q.push_back('{ready: 1'b1, err: 1'b1, en: 1'b0, data: '0});
        end
    endtask

    // Entered just after a falling edge; returns just after the next one.
    task automatic do_cycle(input xfer_t x, input logic stall, output logic accepted);
        logic ready_now;
        HSEL      = x.sel;
        HTRANS    = x.trans;
        HWRITE    = x.wr;
        HSIZE     = x.size;
        HMASTER   = x.mst;
        HADDR     = x.addr;
        bus_stall = stall && (exp_q.size() == 0);
        #1;
        check_outputs();
        ready_now = (exp_q.size() > 0) ? exp_q[0].ready : 1'b1;
        accepted  = ready_now && !bus_stall && x.sel && x.trans[1];
        @(posedge clk);
        if (exp_q.size() > 0) begin
            if (exp_q[0].ready && exp_q[0].en && exp_rd != 32'hFFFF_FFFF) exp_rd++;
            void'(exp_q.pop_front());
        end
        if (accepted) push_response(x);
        @(negedge clk);
    endtask

    function automatic xfer_t mk(input logic [1:0] trans, input logic wr, input logic [3:0] mst,
                                 input logic [ADDR_W-1:0] addr);
        xfer_t x;
        x.sel   = 1'b1;
        x.trans = trans;
        x.wr    = wr;
        x.size  = 3'd2;
        x.mst   = mst;
        x.addr  = addr;
        return x;
    endfunction

    function automatic xfer_t rand_xfer();
        xfer_t x;
        x.sel   = ($urandom_range(0, 9) != 0);
        x.trans = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
        x.wr    = ($urandom_range(0, 7) == 0);
        x.size  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
        x.mst   = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'd2;
        x.addr  = $urandom;
        return x;
    endfunction

    task automatic issue(input xfer_t x);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 16 && !acc; i++) do_cycle(x, 1'b0, acc);
        check("issue_accept", 64'(acc), 64'd1);
    endtask

    task automatic idle_cycles(input int n);
        logic acc;
        xfer_t idle_x;
        idle_x = '0;
        for (int i = 0; i < n; i++) do_cycle(idle_x, 1'b0, acc);
    endtask

    task automatic apply_reset_checks();
        check("rst_hreadyout", 64'(HREADYOUT_S), 64'd1);
        check("rst_hresp", 64'(HRESP_S), 64'd0);
        check("rst_hrdata", 64'(HRDATA_S), 64'd0);
        check("rst_rom_en", 64'(ROM_EN), 64'd0);
        check("rst_rom_oe", 64'(ROM_OE), 64'd0);
        check("rst_rom_a", 64'(ROM_A), 64'd0);
`ifdef AHB_ROM_RDCNT_EN
        check("rst_rd_cnt", 64'(rd_cnt), 64'd0);
`endif
    endtask

    initial begin
        logic acc;
        xfer_t x;
        n_checks  = 0;
        n_fail    = 0;
        exp_a     = '0;
        exp_rd    = 0;
        rst       = 1'b0;
        bus_stall = 1'b0;
        HSEL      = 1'b0;
        HTRANS    = 2'b00;
        HWRITE    = 1'b0;
        HSIZE     = 3'd0;
        HMASTER   = 4'd0;
        HADDR     = '0;
        #1;
        apply_reset_checks();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Single read: word address 4 returns DEADBEEF after one wait cycle.
        issue(mk(2'b10, 1'b0, 4'd2, 32'h0000_0010));
        idle_cycles(3);

        // Back-to-back NONSEQ/SEQ reads with no idle bubble.
        issue(mk(2'b10, 1'b0, 4'd2, 32'h0000_0000));
        issue(mk(2'b11, 1'b0, 4'd2, 32'h0000_0004));
        idle_cycles(3);

        // Write gets a two-cycle ERROR.
        issue(mk(2'b10, 1'b1, 4'd2, 32'h0000_0020));
        idle_cycles(2);

        // Illegal master, then a legal read accepted in ERR2.
        issue(mk(2'b10, 1'b0, 4'd1, 32'h0000_0030));
        issue(mk(2'b10, 1'b0, 4'd2, 32'h0000_0040));
        idle_cycles(3);

        // Oversize transfer.
        x = mk(2'b10, 1'b0, 4'd2, 32'h0000_0050);
        x.size = 3'd3;
        issue(x);
        idle_cycles(2);

        // IDLE and BUSY while selected complete with zero wait states.
        do_cycle(mk(2'b00, 1'b0, 4'd2, 32'h0000_0060), 1'b0, acc);
        do_cycle(mk(2'b01, 1'b0, 4'd2, 32'h0000_0060), 1'b0, acc);

        // Reset asserted in the middle of a WAIT cycle.
        issue(mk(2'b10, 1'b0, 4'd2, 32'h0000_0100));
        #2;
        rst = 1'b0;
        #1;
        apply_reset_checks();
        exp_q.delete();
        exp_a  = '0;
        exp_rd = 0;
        @(negedge clk);
        idle_cycles(1);
        rst = 1'b1;

        for (int i = 0; i < 5; i++) issue(mk(2'b10, 1'b0, 4'd2, ADDR_W'(i * 4 + 8)));
        idle_cycles(2);
`ifdef AHB_ROM_RDCNT_EN
        check("rd_cnt_five", 64'(rd_cnt), 64'd5);
`endif

        // Randomized traffic, including stalls from other slaves while idle.
        for (int i = 0; i < 1500; i++) begin
            do_cycle(rand_xfer(), ($urandom_range(0, 7) == 0), acc);
        end

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) idle_cycles(1);
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        idle_cycles(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
